ps2_kbd_rx: RTL and testbench
=============================

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL provide parameter FILTER_LEN, default 8, meaning consecutive identical samples required to accept a ps2_clk level change.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 65536, meaning clk cycles without a filtered ps2_clk falling edge before a partial frame is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; all logic single clock domain.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 SHALL have port wrdata  output  16  key event word {break, extended, 6'b0, scancode[7:0]}.
REQ-008 SHALL have port wr_en  output  1  one-cycle strobe, wrdata valid; drives the keyboard FIFO write port directly.
REQ-009 SHALL have port frame_err  output  1  one-cycle strobe on discarded frame (start, parity, stop or timeout error).

Function
REQ-010 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any use.
REQ-011 SHALL change filtered clock only after FILTER_LEN consecutive synchronized samples differ from its current value.
REQ-012 SHALL sample synchronized ps2_data on each filtered-clock 1->0 transition; bit index 0..10.
REQ-013 SHALL interpret frame as bit0 start (must be 0), bits1-8 data LSB first, bit9 odd parity over data+parity, bit10 stop (must be 1).
REQ-014 SHALL, on sampling bit10, validate start/parity/stop and return bit index to 0 regardless of result.
REQ-015 SHALL, on invalid frame, pulse frame_err in the cycle after bit10 is sampled, discard the byte, clear pending break/extended flags, not pulse wr_en.
REQ-016 SHALL, on valid byte 0xE0, set extended flag and emit no event.
REQ-017 SHALL, on valid byte 0xF0, set break flag and emit no event.
REQ-018 SHALL, on any other valid byte (including 0xE1, 0xAA, 0xFA), drive wrdata={break,extended,6'b0,byte} and pulse wr_en the cycle after bit10 is sampled, then clear both flags.
REQ-019 SHALL hold wrdata stable between events; wr_en high for exactly one cycle per event.
REQ-020 SHALL never backpressure; downstream full-buffer drops are downstream behaviour.
REQ-021 SHALL keep prefix flags across frames until consumed by an event or cleared by error/reset; repeated 0xE0 or 0xF0 is idempotent.
REQ-022 SHALL ignore filtered-clock rising edges; glitches shorter than FILTER_LEN cycles SHALL produce no edge.

Reset
REQ-023 SHALL on rst_n low immediately force wrdata=0, wr_en=0, frame_err=0, bit index=0, flags=0, timeout counter=0, synchronizers and filtered lines=1.
REQ-024 SHALL discard any frame in progress when reset asserts mid-frame; no event or frame_err on release.
REQ-025 SHALL resume reception with the first start bit after rst_n deasserts.

Configuration
REQ-026 SHALL, with PS2_RX_TIMEOUT_EN defined, count clk cycles while bit index!=0, reset count on each filtered falling edge, and at TIMEOUT_CYCLES return bit index to 0, clear flags, pulse frame_err once.
REQ-027 SHALL, without PS2_RX_TIMEOUT_EN, omit the counter; a partial frame persists indefinitely until completed or reset.

Verification
REQ-028 Frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1) -> one wr_en, wrdata=0x001C, frame_err=0.
REQ-029 Frames F0,1C -> single wr_en, wrdata=0x801C; then E0,F0,75 -> single wr_en, wrdata=0xC075; next 1C -> 0x001C (flags cleared).
REQ-030 Frame 0x1C with parity bit 1 -> frame_err pulse, no wr_en; following valid 0x1C -> 0x001C.
REQ-031 With PS2_RX_TIMEOUT_EN: 5 bits then idle TIMEOUT_CYCLES+10 -> one frame_err; next full 0x1C frame -> 0x001C; without macro same stimulus -> no frame_err, next frame misframed.
REQ-032 Reset asserted after bit 6 of 0x1C, released, then full 0x1C frame -> exactly one wr_en, 0x001C, no frame_err.
REQ-033 ps2_clk glitch low for FILTER_LEN-2 cycles mid-frame -> no extra bit sampled, frame decodes correctly.

Source files
------------

// File: rtl/ps2_kbd_rx_if.sv
// Key-event write port from the PS/2 receiver toward the keyboard FIFO.
// The receiver drives the master side; the FIFO/consumer uses the slave side.
interface ps2_kbd_rx_if;
  logic [15:0] wrdata;
  logic        wr_en;
  logic        frame_err;

  modport master (output wrdata, output wr_en, output frame_err);
  modport slave  (input  wrdata, input  wr_en, input  frame_err);
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 lines, decodes 11-bit frames
// and folds E0/F0 prefixes into one key-event word. Define PS2_RX_TIMEOUT_EN to abandon stalled frames.
module ps2_kbd_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_kbd_rx_if.master kbd_o
);

  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic           clkMeta_q, clkSync_q;
  logic           dataMeta_q, dataSync_q;
  logic           filtClk_q, filtClk_d;
  logic [FCW-1:0] filtCnt_q, filtCnt_d;
  logic           fallEdge;

  logic [3:0]     bitIdx_q, bitIdx_d;
  logic [9:0]     shift_q, shift_d;
  logic           brk_q, brk_d;
  logic           ext_q, ext_d;
  logic [15:0]    wrdata_q, wrdata_d;
  logic           wrEn_q, wrEn_d;
  logic           frameErr_q, frameErr_d;

  logic [7:0]     rxByte;
  logic           frameOk;

  // Both PS/2 lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkMeta_q  <= 1'b1;
      clkSync_q  <= 1'b1;
      dataMeta_q <= 1'b1;
      dataSync_q <= 1'b1;
    end else begin
      clkMeta_q  <= ps2_clk;
      clkSync_q  <= clkMeta_q;
      dataMeta_q <= ps2_data;
      dataSync_q <= dataMeta_q;
    end
  end

  always_comb begin
    filtClk_d = filtClk_q;
    filtCnt_d = '0;
    if (clkSync_q != filtClk_q) begin
      if (filtCnt_q == FCW'(FILTER_LEN - 1)) begin
        filtClk_d = clkSync_q;
      end else begin
        filtCnt_d = filtCnt_q + 1'b1;
      end
    end
  end

  assign fallEdge = filtClk_q & ~filtClk_d;

  // Shift right so that after ten samples shift_q[0] holds the start bit and shift_q[9] the parity.
  assign rxByte  = shift_q[8:1];
  assign frameOk = ~shift_q[0] & (^shift_q[9:1]) & dataSync_q;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TOW-1:0] toCnt_q, toCnt_d;
  logic           timeoutHit;

  assign timeoutHit = (bitIdx_q != 4'd0) && !fallEdge &&
                      (toCnt_q == TOW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    toCnt_d = '0;
    if ((bitIdx_q != 4'd0) && !fallEdge && !timeoutHit) begin
      toCnt_d = toCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toCnt_q <= '0;
    end else begin
      toCnt_q <= toCnt_d;
    end
  end
`else
  logic timeoutHit;
  assign timeoutHit = 1'b0;
`endif

  always_comb begin
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    wrdata_d   = wrdata_q;
    wrEn_d     = 1'b0;
    frameErr_d = 1'b0;

    if (fallEdge) begin
      if (bitIdx_q == 4'd10) begin
        bitIdx_d = 4'd0;
        if (!frameOk) begin
          frameErr_d = 1'b1;
          brk_d      = 1'b0;
          ext_d      = 1'b0;
        end else if (rxByte == 8'hE0) begin
          ext_d = 1'b1;
        end else if (rxByte == 8'hF0) begin
          brk_d = 1'b1;
        end else begin
          wrdata_d = {brk_q, ext_q, 6'b0, rxByte};
          wrEn_d   = 1'b1;
          brk_d    = 1'b0;
          ext_d    = 1'b0;
        end
      end else begin
        shift_d  = {dataSync_q, shift_q[9:1]};
        bitIdx_d = bitIdx_q + 4'd1;
      end
    end

    if (timeoutHit) begin
      bitIdx_d   = 4'd0;
      brk_d      = 1'b0;
      ext_d      = 1'b0;
      frameErr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filtClk_q  <= 1'b1;
      filtCnt_q  <= '0;
      bitIdx_q   <= 4'd0;
      shift_q    <= '0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      wrdata_q   <= '0;
      wrEn_q     <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      filtClk_q  <= filtClk_d;
      filtCnt_q  <= filtCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      wrdata_q   <= wrdata_d;
      wrEn_q     <= wrEn_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign kbd_o.wrdata    = wrdata_q;
  assign kbd_o.wr_en     = wrEn_q;
  assign kbd_o.frame_err = frameErr_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: drives PS/2 frames bit by bit and checks the key-event port.
// Expectations for the stalled-frame step depend on whether PS2_RX_TIMEOUT_EN is defined.
module tb_ps2_kbd_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 300;

  logic clk;
  logic rst_n;
  logic ps2Clk;
  logic ps2Data;

  int testsRun  = 0;
  int failCount = 0;
  int wrCount   = 0;
  int errCount  = 0;
  int wrBase    = 0;
  int errBase   = 0;
  logic [15:0] lastWord = 16'h0000;

  ps2_kbd_rx_if kbdIf ();

  ps2_kbd_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2Clk),
    .ps2_data(ps2Data),
    .kbd_o   (kbdIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle the strobes are high, so a stuck strobe shows up as extra events.
  always @(negedge clk) begin
    if (rst_n) begin
      if (kbdIf.wr_en) begin
        wrCount  = wrCount + 1;
        lastWord = kbdIf.wrdata;
      end
      if (kbdIf.frame_err) errCount = errCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun = testsRun + 1;
    assert (obs === exp) else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2Bit(input logic b, input bit glitch);
    ps2Data = b;
    waitCycles(10);
    if (glitch) begin
      ps2Clk = 1'b0;
      waitCycles(FILTER_LEN - 2);
      ps2Clk = 1'b1;
      waitCycles(10);
    end else begin
      waitCycles(10);
    end
    ps2Clk = 1'b0;
    waitCycles(20);
    ps2Clk = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit badParity, input int nBits,
                               input int glitchBit);
    logic [10:0] f;
    f[0]    = 1'b0;
    f[8:1]  = b;
    f[9]    = (~^b) ^ badParity;
    f[10]   = 1'b1;
    for (int i = 0; i < nBits; i++) begin
      ps2Bit(f[i], (i == glitchBit));
    end
    ps2Data = 1'b1;
    waitCycles(40);
  endtask

  task automatic markCounts();
    wrBase  = wrCount;
    errBase = errCount;
  endtask

  task automatic checkEvent(input string tag, input int expWr, input int expErr,
                            input logic [15:0] expWord);
    checkOutput($sformatf("%s_wr_en_count", tag), 16'(wrCount - wrBase), 16'(expWr));
    checkOutput($sformatf("%s_frame_err_count", tag), 16'(errCount - errBase), 16'(expErr));
    if (expWr > 0) checkOutput($sformatf("%s_wrdata", tag), lastWord, expWord);
  endtask

  initial begin
    rst_n   = 1'b0;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    waitCycles(5);
    checkOutput("reset_wrdata", kbdIf.wrdata, 16'h0000);
    checkOutput("reset_wr_en", {15'b0, kbdIf.wr_en}, 16'h0000);
    checkOutput("reset_frame_err", {15'b0, kbdIf.frame_err}, 16'h0000);
    rst_n = 1'b1;
    waitCycles(10);

    markCounts();
    applyStimulus(8'h1C, 1'b0, 11, -1);
    checkEvent("make_1c", 1, 0, 16'h001C);

    markCounts();
    applyStimulus(8'hF0, 1'b0, 11, -1);
    checkEvent("prefix_f0_only", 0, 0, 16'h0000);
    applyStimulus(8'h1C, 1'b0, 11, -1);
    checkEvent("break_1c", 1, 0, 16'h801C);

    markCounts();
    applyStimulus(8'hE0, 1'b0, 11, -1);
    applyStimulus(8'hF0, 1'b0, 11, -1);
    applyStimulus(8'h75, 1'b0, 11, -1);
    checkEvent("ext_break_75", 1, 0, 16'hC075);

    markCounts();
    applyStimulus(8'h1C, 1'b0, 11, -1);
    checkEvent("flags_cleared_1c", 1, 0, 16'h001C);

    markCounts();
    applyStimulus(8'hE0, 1'b0, 11, -1);
    applyStimulus(8'hE0, 1'b0, 11, -1);
    applyStimulus(8'h75, 1'b0, 11, -1);
    checkEvent("double_e0_75", 1, 0, 16'h4075);

    markCounts();
    applyStimulus(8'hAA, 1'b0, 11, -1);
    checkEvent("passthru_aa", 1, 0, 16'h00AA);

    markCounts();
    applyStimulus(8'h1C, 1'b1, 11, -1);
    checkEvent("bad_parity", 0, 1, 16'h0000);
    markCounts();
    applyStimulus(8'h1C, 1'b0, 11, -1);
    checkEvent("after_parity_err", 1, 0, 16'h001C);

    markCounts();
    applyStimulus(8'hF0, 1'b0, 11, -1);
    applyStimulus(8'h1C, 1'b1, 11, -1);
    checkEvent("err_after_f0", 0, 1, 16'h0000);
    markCounts();
    applyStimulus(8'h1C, 1'b0, 11, -1);
    checkEvent("err_clears_break", 1, 0, 16'h001C);
    checkOutput("wrdata_hold", kbdIf.wrdata, 16'h001C);

    markCounts();
    applyStimulus(8'h1C, 1'b0, 7, -1);
    rst_n = 1'b0;
    waitCycles(5);
    checkOutput("midframe_reset_wrdata", kbdIf.wrdata, 16'h0000);
    rst_n = 1'b1;
    waitCycles(10);
    applyStimulus(8'h1C, 1'b0, 11, -1);
    checkEvent("after_midframe_reset", 1, 0, 16'h001C);

    markCounts();
    applyStimulus(8'h1C, 1'b0, 11, 4);
    checkEvent("glitch_1c", 1, 0, 16'h001C);

    markCounts();
    applyStimulus(8'h1C, 1'b0, 5, -1);
    waitCycles(TIMEOUT_CYCLES + 10);
`ifdef PS2_RX_TIMEOUT_EN
    checkEvent("stall_timeout", 0, 1, 16'h0000);
    markCounts();
    applyStimulus(8'h1C, 1'b0, 11, -1);
    checkEvent("after_timeout", 1, 0, 16'h001C);
`else
    checkEvent("stall_no_timeout", 0, 0, 16'h0000);
    markCounts();
    applyStimulus(8'h1C, 1'b0, 11, -1);
    checkEvent("misframed_after_stall", 0, 1, 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
